intc_cpu_req: RTL and testbench
===============================

# intc_cpu_req

CPU-side request/acknowledge controller of the interrupt controller. It takes the combinational winner of the 32-source priority tree (`{valid, level[3:0], vector[7:0]}`) and compares it against the CPU interrupt mask. It presents a stable registered request to the CPU, completes the acknowledge handshake, and returns a one-cycle clear pulse to the accepted source. One instance exists per CPU.

## Interface

Parameters:

- `DW`, 5: priority-field width per source, `{valid, level}`.
- `PRI_DW`, 4: level width.
- `NSRC`, 32: number of sources.
- `VEC_BASE`, 64: vector number of source 0.

Ports:

- `clk`  in  1  clock. Single clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `sel_i`  in  DW+8  tree winner:
  - `[DW+7]` valid.
  - `[DW+6:8]` level.
  - `[7:0]` vector.
- `imask_i`  in  PRI_DW  CPU current mask level (SR.I).
- `int_req_o`  out  1  interrupt request to CPU.
- `int_level_o`  out  PRI_DW  latched level of the pending request.
- `int_vec_o`  out  8  latched vector of the pending request.
- `int_ack_i`  in  1  CPU accept. Sampled only while `int_req_o`=1.
- `src_clr_o`  out  NSRC  one-hot, one-cycle pending-clear to the accepted source.
- `busy_o`  out  1  FSM not in IDLE.

## Operation

- Qualified candidate (`cand`): `sel_i` valid=1 and level > `imask_i`. Unsigned compare.
- FSM states and transitions:
  - IDLE → REQ when `cand`. Latch level and vector.
  - REQ, `int_ack_i`=1 → CLR. Drop request.
  - REQ, `cand`=0 with no ack → IDLE. The request is withdrawn; level-source semantics.
  - REQ, `cand` with level > latched level and no ack → stay in REQ. Re-latch the new level/vector (preemption) while request stays high.
  - CLR → GAP. `src_clr_o[vec-VEC_BASE]`=1 for this cycle only.
  - GAP → IDLE. One holdoff cycle so the source pending bit and the CPU's new `imask_i` settle before re-evaluation.
- Simultaneous events:
  - Ack together with preemption or withdrawal: ack wins. The latched (acked) vector is cleared and nothing is re-latched.
  - Equal-level different vector while in REQ: no re-latch. The existing request is kept.
- Vector outside `[VEC_BASE, VEC_BASE+NSRC-1]`: handshake completes normally; `src_clr_o` stays all-zero.
- `int_ack_i` outside REQ: ignored.
- `int_level_o` and `int_vec_o` hold their last latched values after ack; they are meaningful only while `int_req_o`=1.
- Reset, including mid-handshake, forces:
  - state IDLE;
  - `int_req_o`=0, `int_level_o`=0, `int_vec_o`=0;
  - `src_clr_o`=0, `busy_o`=0.

## Timing

- All outputs are registered; no combinational path from `sel_i`, `imask_i` or `int_ack_i` to any output.
- Request latency: `cand` at edge N → `int_req_o`=1 with latched values in cycle N+1.
- While in REQ, `int_req_o` holds and values change only on preemption (visible one cycle after `cand`) or on withdrawal (request low one cycle later).
- Ack at edge M → in cycle M+1, `int_req_o`=0 and the `src_clr_o` pulse is active (CLR).
  - M+2 is GAP.
  - M+3 is IDLE evaluation.
  - Earliest next `int_req_o` is in cycle M+4.
- Back-to-back acks: impossible by construction; the minimum request-to-request spacing is 3 cycles.

## Structure

- Shared package `intc_pkg`:
  - state enum `intc_req_st_e` (IDLE, REQ, CLR, GAP);
  - `INTC_VEC_BASE`;
  - field-position localparams for valid/level/vector in the tree word.
- Sub-module `intc_clr_dec`: vector → one-hot NSRC decoder with range check. It is reused by the software-clear path.

## Test plan

- Reset, then `sel_i`={1,4'd5,8'd70} with `imask_i`=3 → `int_req_o`=1 next cycle, level 5, vec 70. Ack → next cycle `int_req_o`=0 and `src_clr_o`=32'h0000_0040 for exactly 1 cycle. `busy_o` falls 3 cycles after ack.
- Level 3 with `imask_i`=3 → no request. Raise to level 4 → request.
- In REQ (level 5, vec 70), switch `sel_i` to {1,4'd9,8'd90} → `int_vec_o`=90, `int_level_o`=9, `int_req_o` stays high. Ack → `src_clr_o` bit 26 only.
- Withdraw (`sel_i` valid=0) in the same cycle as ack → CLR pulse for the latched vector is still issued. Withdraw without ack → `int_req_o` low next cycle and no clear.
- Vector 8'd10 acked → handshake completes and `src_clr_o`=0. Assert `rst` during CLR → all outputs 0 next cycle and FSM in IDLE.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared types and tree-word field positions for the interrupt controller.
// Imported by the CPU request controller and the clear decoder.
package intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CLR  = 2'd2,
        ST_GAP  = 2'd3
    } intc_req_st_e;

    localparam int INTC_VEC_BASE = 64;
    localparam int INTC_NSRC     = 32;
    localparam int INTC_DW       = 5;
    localparam int INTC_PRI_DW   = 4;

    // Tree word layout: {valid, level, vector[7:0]}
    localparam int INTC_VEC_LO    = 0;
    localparam int INTC_VEC_HI    = 7;
    localparam int INTC_LVL_LO    = 8;
    localparam int INTC_LVL_HI    = INTC_DW + 6;
    localparam int INTC_VALID_POS = INTC_DW + 7;

endpackage

// File: rtl/intc_clr_dec.sv
// Vector number to one-hot source-clear decoder with range check.
// Vectors outside [VEC_BASE, VEC_BASE+NSRC-1] decode to all-zero.
module intc_clr_dec
    import intc_pkg::*;
#(
    parameter int NSRC     = INTC_NSRC,
    parameter int VEC_BASE = INTC_VEC_BASE
) (
    input  logic [7:0]      vec,
    output logic [NSRC-1:0] onehot
);

    localparam int             IW      = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [8:0]     BASE    = 9'(VEC_BASE);
    localparam logic [8:0]     LIMIT   = 9'(VEC_BASE + NSRC);
    localparam logic [IW-1:0]  BASE_LO = IW'(VEC_BASE);

    logic [8:0]    vec_ext_s;
    logic          in_range_s;
    logic [IW-1:0] off_s;

    assign vec_ext_s  = {1'b0, vec};
    assign in_range_s = (vec_ext_s >= BASE) && (vec_ext_s < LIMIT);
    // Only the low bits of the offset matter once the range check has passed.
    assign off_s      = vec[IW-1:0] - BASE_LO;

    // One-hot decode of the in-range offset
    always_comb begin
        onehot = '0;
        if (in_range_s) begin
            onehot[off_s] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/intc_cpu_req.sv
// CPU-side interrupt request/acknowledge controller: masks the tree winner,
// holds a registered request to the CPU and pulses the accepted source's clear.
module intc_cpu_req
    import intc_pkg::*;
#(
    parameter int DW       = INTC_DW,
    parameter int PRI_DW   = INTC_PRI_DW,
    parameter int NSRC     = INTC_NSRC,
    parameter int VEC_BASE = INTC_VEC_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW+7:0]     sel_i,
    input  logic [PRI_DW-1:0] imask_i,
    output logic              int_req_o,
    output logic [PRI_DW-1:0] int_level_o,
    output logic [7:0]        int_vec_o,
    input  logic              int_ack_i,
    output logic [NSRC-1:0]   src_clr_o,
    output logic              busy_o
);

    localparam int VALID_POS = DW + 7;
    localparam int LVL_HI    = DW + 6;

    intc_req_st_e      state_r;
    intc_req_st_e      state_next_s;
    logic              sel_valid_s;
    logic [PRI_DW-1:0] sel_level_s;
    logic [7:0]        sel_vec_s;
    logic              cand_s;
    logic              latch_s;
    logic [NSRC-1:0]   dec_clr_s;

    assign sel_valid_s = sel_i[VALID_POS];
    assign sel_level_s = sel_i[LVL_HI:INTC_LVL_LO];
    assign sel_vec_s   = sel_i[INTC_VEC_HI:INTC_VEC_LO];
    assign cand_s      = sel_valid_s && (sel_level_s > imask_i);

    // Decode from the latched vector so the clear targets what the CPU acked
    intc_clr_dec #(
        .NSRC     (NSRC),
        .VEC_BASE (VEC_BASE)
    ) u_clr_dec (
        .vec    (int_vec_o),
        .onehot (dec_clr_s)
    );

    // Next-state and latch-enable logic; ack takes priority over withdrawal/preemption
    always_comb begin
        state_next_s = state_r;
        latch_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cand_s) begin
                    state_next_s = ST_REQ;
                    latch_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (int_ack_i) begin
                    state_next_s = ST_CLR;
                end else if (!cand_s) begin
                    state_next_s = ST_IDLE;
                end else if (sel_level_s > int_level_o) begin
                    state_next_s = ST_REQ;
                    latch_s      = 1'b1;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_CLR:  state_next_s = ST_GAP;
            ST_GAP:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and registered outputs derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            int_req_o   <= 1'b0;
            int_level_o <= '0;
            int_vec_o   <= 8'd0;
            src_clr_o   <= '0;
            busy_o      <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            int_req_o <= (state_next_s == ST_REQ);
            busy_o    <= (state_next_s != ST_IDLE);
            src_clr_o <= (state_next_s == ST_CLR) ? dec_clr_s : '0;
            if (latch_s) begin
                int_level_o <= sel_level_s;
                int_vec_o   <= sel_vec_s;
            end
        end
    end

endmodule

// File: tb/tb_intc_cpu_req.sv
// Scoreboard bench for intc_cpu_req: per-cycle stimulus with expected outputs
// queued up front and compared one cycle after each drive.
module tb_intc_cpu_req;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] sel_i = 13'd0;
    logic [3:0]  imask_i = 4'd0;
    logic        int_ack_i = 1'b0;
    logic        int_req_o;
    logic [3:0]  int_level_o;
    logic [7:0]  int_vec_o;
    logic [31:0] src_clr_o;
    logic        busy_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rst;
        logic [12:0] sel;
        logic [3:0]  mask;
        logic        ack;
        logic        req;
        logic [3:0]  lvl;
        logic [7:0]  vec;
        logic [31:0] clr;
        logic        busy;
    } step_t;

    step_t sb[$];

    always #5 clk = ~clk;

    intc_cpu_req dut (
        .clk         (clk),
        .rst         (rst),
        .sel_i       (sel_i),
        .imask_i     (imask_i),
        .int_req_o   (int_req_o),
        .int_level_o (int_level_o),
        .int_vec_o   (int_vec_o),
        .int_ack_i   (int_ack_i),
        .src_clr_o   (src_clr_o),
        .busy_o      (busy_o)
    );

    function automatic logic [12:0] w(input logic v, input logic [3:0] l, input logic [7:0] x);
        return {v, l, x};
    endfunction

    function automatic void push(input logic r, input logic [12:0] s, input logic [3:0] m,
                                 input logic a, input logic q, input logic [3:0] l,
                                 input logic [7:0] x, input logic [31:0] c, input logic b);
        step_t e;
        e.rst = r; e.sel = s; e.mask = m; e.ack = a;
        e.req = q; e.lvl = l; e.vec = x; e.clr = c; e.busy = b;
        sb.push_back(e);
    endfunction

    task automatic test_reset();
        step_t e;
        int n = 0;
        push(1'b1, 13'd0, 4'd0, 1'b0, 1'b0, 4'd0, 8'd0, 32'h0, 1'b0);
        push(1'b0, 13'd0, 4'd0, 1'b1, 1'b0, 4'd0, 8'd0, 32'h0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); rst = e.rst; sel_i = e.sel; imask_i = e.mask; int_ack_i = e.ack;
            @(posedge clk); #1;
            tests++;
            if ({int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o} !== {e.req, e.lvl, e.vec, e.clr, e.busy}) begin
                fails++;
                $display("FAIL reset step %0d: got req=%b lvl=%0d vec=%0d clr=%h busy=%b, expected req=%b lvl=%0d vec=%0d clr=%h busy=%b",
                         n, int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o, e.req, e.lvl, e.vec, e.clr, e.busy);
            end
            n++;
        end
    endtask

    task automatic test_basic();
        step_t e;
        int n = 0;
        push(1'b1, 13'd0,           4'd3, 1'b0, 1'b0, 4'd0, 8'd0,  32'h0,  1'b0);
        push(1'b0, w(1'b1,4'd5,8'd70), 4'd3, 1'b0, 1'b1, 4'd5, 8'd70, 32'h0,  1'b1);
        push(1'b0, w(1'b1,4'd5,8'd70), 4'd3, 1'b0, 1'b1, 4'd5, 8'd70, 32'h0,  1'b1);
        push(1'b0, w(1'b1,4'd5,8'd70), 4'd3, 1'b1, 1'b0, 4'd5, 8'd70, 32'h40, 1'b1);
        push(1'b0, 13'd0,           4'd3, 1'b0, 1'b0, 4'd5, 8'd70, 32'h0,  1'b1);
        push(1'b0, 13'd0,           4'd3, 1'b0, 1'b0, 4'd5, 8'd70, 32'h0,  1'b0);
        push(1'b0, 13'd0,           4'd3, 1'b0, 1'b0, 4'd5, 8'd70, 32'h0,  1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); rst = e.rst; sel_i = e.sel; imask_i = e.mask; int_ack_i = e.ack;
            @(posedge clk); #1;
            tests++;
            if ({int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o} !== {e.req, e.lvl, e.vec, e.clr, e.busy}) begin
                fails++;
                $display("FAIL basic step %0d: got req=%b lvl=%0d vec=%0d clr=%h busy=%b, expected req=%b lvl=%0d vec=%0d clr=%h busy=%b",
                         n, int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o, e.req, e.lvl, e.vec, e.clr, e.busy);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        step_t e;
        int n = 0;
        push(1'b1, 13'd0,              4'd3, 1'b0, 1'b0, 4'd0, 8'd0,  32'h0,  1'b0);
        push(1'b0, w(1'b1,4'd5,8'd70), 4'd3, 1'b0, 1'b1, 4'd5, 8'd70, 32'h0,  1'b1);
        push(1'b0, w(1'b1,4'd5,8'd70), 4'd3, 1'b1, 1'b0, 4'd5, 8'd70, 32'h40, 1'b1);
        push(1'b0, w(1'b1,4'd5,8'd70), 4'd3, 1'b1, 1'b0, 4'd5, 8'd70, 32'h0,  1'b1);
        push(1'b0, w(1'b1,4'd5,8'd70), 4'd3, 1'b1, 1'b0, 4'd5, 8'd70, 32'h0,  1'b0);
        push(1'b0, w(1'b1,4'd5,8'd70), 4'd3, 1'b0, 1'b1, 4'd5, 8'd70, 32'h0,  1'b1);
        push(1'b0, w(1'b1,4'd5,8'd70), 4'd3, 1'b0, 1'b1, 4'd5, 8'd70, 32'h0,  1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); rst = e.rst; sel_i = e.sel; imask_i = e.mask; int_ack_i = e.ack;
            @(posedge clk); #1;
            tests++;
            if ({int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o} !== {e.req, e.lvl, e.vec, e.clr, e.busy}) begin
                fails++;
                $display("FAIL back_to_back step %0d: got req=%b lvl=%0d vec=%0d clr=%h busy=%b, expected req=%b lvl=%0d vec=%0d clr=%h busy=%b",
                         n, int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o, e.req, e.lvl, e.vec, e.clr, e.busy);
            end
            n++;
        end
    endtask

    task automatic test_mask();
        step_t e;
        int n = 0;
        push(1'b1, 13'd0,               4'd3,  1'b0, 1'b0, 4'd0,  8'd0,  32'h0, 1'b0);
        push(1'b0, w(1'b1,4'd3,8'd70),  4'd3,  1'b0, 1'b0, 4'd0,  8'd0,  32'h0, 1'b0);
        push(1'b0, w(1'b1,4'd3,8'd70),  4'd3,  1'b0, 1'b0, 4'd0,  8'd0,  32'h0, 1'b0);
        push(1'b0, w(1'b1,4'd4,8'd70),  4'd3,  1'b0, 1'b1, 4'd4,  8'd70, 32'h0, 1'b1);
        push(1'b0, w(1'b1,4'd15,8'd70), 4'd15, 1'b0, 1'b0, 4'd4,  8'd70, 32'h0, 1'b0);
        push(1'b0, w(1'b1,4'd15,8'd71), 4'd14, 1'b0, 1'b1, 4'd15, 8'd71, 32'h0, 1'b1);
        push(1'b0, w(1'b0,4'd15,8'd71), 4'd0,  1'b0, 1'b0, 4'd15, 8'd71, 32'h0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); rst = e.rst; sel_i = e.sel; imask_i = e.mask; int_ack_i = e.ack;
            @(posedge clk); #1;
            tests++;
            if ({int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o} !== {e.req, e.lvl, e.vec, e.clr, e.busy}) begin
                fails++;
                $display("FAIL mask step %0d: got req=%b lvl=%0d vec=%0d clr=%h busy=%b, expected req=%b lvl=%0d vec=%0d clr=%h busy=%b",
                         n, int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o, e.req, e.lvl, e.vec, e.clr, e.busy);
            end
            n++;
        end
    endtask

    task automatic test_preempt();
        step_t e;
        int n = 0;
        push(1'b1, 13'd0,              4'd3, 1'b0, 1'b0, 4'd0, 8'd0,  32'h0,         1'b0);
        push(1'b0, w(1'b1,4'd5,8'd70), 4'd3, 1'b0, 1'b1, 4'd5, 8'd70, 32'h0,         1'b1);
        push(1'b0, w(1'b1,4'd9,8'd90), 4'd3, 1'b0, 1'b1, 4'd9, 8'd90, 32'h0,         1'b1);
        push(1'b0, w(1'b1,4'd9,8'd91), 4'd3, 1'b0, 1'b1, 4'd9, 8'd90, 32'h0,         1'b1);
        push(1'b0, w(1'b1,4'd7,8'd80), 4'd3, 1'b0, 1'b1, 4'd9, 8'd90, 32'h0,         1'b1);
        push(1'b0, 13'd0,              4'd3, 1'b1, 1'b0, 4'd9, 8'd90, 32'h0400_0000, 1'b1);
        push(1'b0, 13'd0,              4'd3, 1'b0, 1'b0, 4'd9, 8'd90, 32'h0,         1'b1);
        push(1'b0, 13'd0,              4'd3, 1'b0, 1'b0, 4'd9, 8'd90, 32'h0,         1'b0);
        // ack coinciding with a higher-level candidate: the acked vector is cleared
        push(1'b0, w(1'b1,4'd5,8'd70), 4'd3, 1'b0, 1'b1, 4'd5, 8'd70, 32'h0,         1'b1);
        push(1'b0, w(1'b1,4'd9,8'd90), 4'd3, 1'b1, 1'b0, 4'd5, 8'd70, 32'h40,        1'b1);
        push(1'b0, w(1'b1,4'd9,8'd90), 4'd3, 1'b0, 1'b0, 4'd5, 8'd70, 32'h0,         1'b1);
        push(1'b0, w(1'b1,4'd9,8'd90), 4'd3, 1'b0, 1'b0, 4'd5, 8'd70, 32'h0,         1'b0);
        push(1'b0, w(1'b1,4'd9,8'd90), 4'd3, 1'b0, 1'b1, 4'd9, 8'd90, 32'h0,         1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); rst = e.rst; sel_i = e.sel; imask_i = e.mask; int_ack_i = e.ack;
            @(posedge clk); #1;
            tests++;
            if ({int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o} !== {e.req, e.lvl, e.vec, e.clr, e.busy}) begin
                fails++;
                $display("FAIL preempt step %0d: got req=%b lvl=%0d vec=%0d clr=%h busy=%b, expected req=%b lvl=%0d vec=%0d clr=%h busy=%b",
                         n, int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o, e.req, e.lvl, e.vec, e.clr, e.busy);
            end
            n++;
        end
    endtask

    task automatic test_withdraw();
        step_t e;
        int n = 0;
        push(1'b1, 13'd0,              4'd3, 1'b0, 1'b0, 4'd0, 8'd0,  32'h0,  1'b0);
        push(1'b0, w(1'b1,4'd5,8'd70), 4'd3, 1'b0, 1'b1, 4'd5, 8'd70, 32'h0,  1'b1);
        push(1'b0, w(1'b0,4'd5,8'd70), 4'd3, 1'b1, 1'b0, 4'd5, 8'd70, 32'h40, 1'b1);
        push(1'b0, 13'd0,              4'd3, 1'b0, 1'b0, 4'd5, 8'd70, 32'h0,  1'b1);
        push(1'b0, 13'd0,              4'd3, 1'b0, 1'b0, 4'd5, 8'd70, 32'h0,  1'b0);
        push(1'b0, w(1'b1,4'd6,8'd72), 4'd3, 1'b0, 1'b1, 4'd6, 8'd72, 32'h0,  1'b1);
        push(1'b0, w(1'b0,4'd6,8'd72), 4'd3, 1'b0, 1'b0, 4'd6, 8'd72, 32'h0,  1'b0);
        push(1'b0, 13'd0,              4'd3, 1'b1, 1'b0, 4'd6, 8'd72, 32'h0,  1'b0);
        push(1'b0, 13'd0,              4'd3, 1'b0, 1'b0, 4'd6, 8'd72, 32'h0,  1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); rst = e.rst; sel_i = e.sel; imask_i = e.mask; int_ack_i = e.ack;
            @(posedge clk); #1;
            tests++;
            if ({int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o} !== {e.req, e.lvl, e.vec, e.clr, e.busy}) begin
                fails++;
                $display("FAIL withdraw step %0d: got req=%b lvl=%0d vec=%0d clr=%h busy=%b, expected req=%b lvl=%0d vec=%0d clr=%h busy=%b",
                         n, int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o, e.req, e.lvl, e.vec, e.clr, e.busy);
            end
            n++;
        end
    endtask

    task automatic test_range();
        step_t e;
        int n = 0;
        logic [7:0] vecs [5] = '{8'd10, 8'd95, 8'd64, 8'd96, 8'd63};
        logic [31:0] clrs [5] = '{32'h0, 32'h8000_0000, 32'h0000_0001, 32'h0, 32'h0};
        push(1'b1, 13'd0, 4'd0, 1'b0, 1'b0, 4'd0, 8'd0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push(1'b0, w(1'b1,4'd2,vecs[i]), 4'd0, 1'b0, 1'b1, 4'd2, vecs[i], 32'h0,   1'b1);
            push(1'b0, 13'd0,                4'd0, 1'b1, 1'b0, 4'd2, vecs[i], clrs[i], 1'b1);
            push(1'b0, 13'd0,                4'd0, 1'b0, 1'b0, 4'd2, vecs[i], 32'h0,   1'b1);
            push(1'b0, 13'd0,                4'd0, 1'b0, 1'b0, 4'd2, vecs[i], 32'h0,   1'b0);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); rst = e.rst; sel_i = e.sel; imask_i = e.mask; int_ack_i = e.ack;
            @(posedge clk); #1;
            tests++;
            if ({int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o} !== {e.req, e.lvl, e.vec, e.clr, e.busy}) begin
                fails++;
                $display("FAIL range step %0d: got req=%b lvl=%0d vec=%0d clr=%h busy=%b, expected req=%b lvl=%0d vec=%0d clr=%h busy=%b",
                         n, int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o, e.req, e.lvl, e.vec, e.clr, e.busy);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid();
        step_t e;
        int n = 0;
        push(1'b1, 13'd0,              4'd3, 1'b0, 1'b0, 4'd0, 8'd0,  32'h0,  1'b0);
        push(1'b0, w(1'b1,4'd5,8'd70), 4'd3, 1'b0, 1'b1, 4'd5, 8'd70, 32'h0,  1'b1);
        push(1'b0, w(1'b1,4'd5,8'd70), 4'd3, 1'b1, 1'b0, 4'd5, 8'd70, 32'h40, 1'b1);
        push(1'b1, w(1'b1,4'd5,8'd70), 4'd3, 1'b0, 1'b0, 4'd0, 8'd0,  32'h0,  1'b0);
        // IDLE immediately after reset: a standing candidate requests at once
        push(1'b0, w(1'b1,4'd6,8'd71), 4'd3, 1'b0, 1'b1, 4'd6, 8'd71, 32'h0,  1'b1);
        push(1'b1, w(1'b1,4'd6,8'd71), 4'd3, 1'b1, 1'b0, 4'd0, 8'd0,  32'h0,  1'b0);
        push(1'b0, 13'd0,              4'd3, 1'b0, 1'b0, 4'd0, 8'd0,  32'h0,  1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); rst = e.rst; sel_i = e.sel; imask_i = e.mask; int_ack_i = e.ack;
            @(posedge clk); #1;
            tests++;
            if ({int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o} !== {e.req, e.lvl, e.vec, e.clr, e.busy}) begin
                fails++;
                $display("FAIL reset_mid step %0d: got req=%b lvl=%0d vec=%0d clr=%h busy=%b, expected req=%b lvl=%0d vec=%0d clr=%h busy=%b",
                         n, int_req_o, int_level_o, int_vec_o, src_clr_o, busy_o, e.req, e.lvl, e.vec, e.clr, e.busy);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_mask();
        test_preempt();
        test_withdraw();
        test_range();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
